// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: writeback, operand reads, destination claims and scoreboard view.
// The master drives writes, read addresses and claims. The slave (the register file) returns data and busy state.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2
);
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic                claim_ok;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output we, wa, wd, ra, claim_en, claim_addr,
        input  rd, rd_busy, claim_ok, busy_vec
    );

    modport slave (
        input  we, wa, wd, ra, claim_en, claim_addr,
        output rd, rd_busy, claim_ok, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Reads are combinational with write-first bypass. A claim marks a destination busy until its writeback.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus_io
);
    logic [XLEN-1:0]     regs_q [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic                wr_en;
    logic                claim_ok;
    logic                claim_set;
    logic [NRD*XLEN-1:0] rd_c;
    logic [NRD-1:0]      rd_busy_c;

    // A claim is applied after the write clear, so the new producer wins on a same-address collision.
    always_comb begin
        wr_en     = bus_io.we && !(ZERO_REG && bus_io.wa == '0);
        claim_ok  = bus_io.claim_en && !rst &&
                    (!busy_q[bus_io.claim_addr] ||
                     (bus_io.we && bus_io.wa == bus_io.claim_addr));
        claim_set = claim_ok && !(ZERO_REG && bus_io.claim_addr == '0);
        busy_d    = busy_q;
        if (wr_en) begin
            busy_d[bus_io.wa] = 1'b0;
        end
        if (claim_set) begin
            busy_d[bus_io.claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int unsigned n = 0; n < NREGS; n++) begin
                regs_q[n] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_en) begin
                regs_q[bus_io.wa] <= bus_io.wd;
            end
        end
    end

    // Outputs are forced to zero while reset is held, because the bypass path would otherwise leak wd.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;
        logic          zero;

        assign addr                    = bus_io.ra[i*AW +: AW];
        assign hit                     = bus_io.we && (bus_io.wa == addr);
        assign zero                    = rst || (ZERO_REG && addr == '0);
        assign rd_c[i*XLEN +: XLEN]    = zero ? '0 : (hit ? bus_io.wd : regs_q[addr]);
        assign rd_busy_c[i]            = !zero && busy_q[addr] && !hit;
    end

    assign bus_io.rd       = rd_c;
    assign bus_io.rd_busy  = rd_busy_c;
    assign bus_io.claim_ok = claim_ok;
    assign bus_io.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard with an array-based reference model.
// The bench covers two instances: a default 32x32 file with a hardwired zero, and a 16x64 four-port file without one.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2)) if0 ();
    regfile_scoreboard_if #(.XLEN(64), .NREGS(16), .AW(4), .NRD(4)) if1 ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_REG(1'b1)) u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if0)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .AW(4), .NRD(4), .ZERO_REG(1'b0)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if1)
    );

    // Stimulus per instance, held at maximum widths.
    logic        s_we [2];
    logic [4:0]  s_wa [2];
    logic [63:0] s_wd [2];
    logic [4:0]  s_ra [2][4];
    logic        s_ce [2];
    logic [4:0]  s_ca [2];

    // Reference state.
    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];

    function automatic int xlen_of(int k);  return (k == 0) ? 32 : 64; endfunction
    function automatic int nregs_of(int k); return (k == 0) ? 32 : 16; endfunction
    function automatic int nrd_of(int k);   return (k == 0) ? 2 : 4;   endfunction
    function automatic bit zr_of(int k);    return (k == 0);           endfunction
    function automatic logic [63:0] mask_of(int k);
        return (k == 0) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [255:0] exp_rd(int k);
        logic [255:0] e;
        e = '0;
        for (int i = 0; i < nrd_of(k); i++) begin
            logic [63:0] v;
            logic [4:0]  a;
            a = s_ra[k][i];
            if (rst || (zr_of(k) && a == 0)) v = '0;
            else if (s_we[k] && s_wa[k] == a) v = s_wd[k] & mask_of(k);
            else v = m_reg[k][a];
            e = e | (256'(v) << (i * xlen_of(k)));
        end
        return e;
    endfunction

    function automatic logic [255:0] exp_rdb(int k);
        logic [255:0] e;
        e = '0;
        for (int i = 0; i < nrd_of(k); i++) begin
            logic [4:0] a;
            a = s_ra[k][i];
            e[i] = !rst && !(zr_of(k) && a == 0) && m_busy[k][a] &&
                   !(s_we[k] && s_wa[k] == a);
        end
        return e;
    endfunction

    function automatic bit exp_cok(int k);
        return s_ce[k] && !rst && (!m_busy[k][s_ca[k]] || (s_we[k] && s_wa[k] == s_ca[k]));
    endfunction

    function automatic logic [255:0] exp_bv(int k);
        logic [255:0] e;
        e = '0;
        for (int n = 0; n < nregs_of(k); n++) e[n] = m_busy[k][n];
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 32; n++) begin
                    m_reg[k][n]  <= '0;
                    m_busy[k][n] <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (s_we[k] && !(zr_of(k) && s_wa[k] == 0)) begin
                    m_reg[k][s_wa[k]]  <= s_wd[k] & mask_of(k);
                    m_busy[k][s_wa[k]] <= 1'b0;
                end
                if (exp_cok(k) && !(zr_of(k) && s_ca[k] == 0)) m_busy[k][s_ca[k]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("i0.rd",       256'(if0.rd),       exp_rd(0));
        chk("i0.rd_busy",  256'(if0.rd_busy),  exp_rdb(0));
        chk("i0.claim_ok", 256'(if0.claim_ok), 256'(exp_cok(0)));
        chk("i0.busy_vec", 256'(if0.busy_vec), exp_bv(0));
        chk("i1.rd",       256'(if1.rd),       exp_rd(1));
        chk("i1.rd_busy",  256'(if1.rd_busy),  exp_rdb(1));
        chk("i1.claim_ok", 256'(if1.claim_ok), 256'(exp_cok(1)));
        chk("i1.busy_vec", 256'(if1.busy_vec), exp_bv(1));
    endtask

    always @(negedge clk) if (chk_on) check_all();

    task automatic apply();
        if0.we         = s_we[0];
        if0.wa         = s_wa[0];
        if0.wd         = s_wd[0][31:0];
        if0.ra         = {s_ra[0][1], s_ra[0][0]};
        if0.claim_en   = s_ce[0];
        if0.claim_addr = s_ca[0];
        if1.we         = s_we[1];
        if1.wa         = s_wa[1][3:0];
        if1.wd         = s_wd[1];
        if1.ra         = {s_ra[1][3][3:0], s_ra[1][2][3:0], s_ra[1][1][3:0], s_ra[1][0][3:0]};
        if1.claim_en   = s_ce[1];
        if1.claim_addr = s_ca[1][3:0];
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            s_we[k] = 1'b0;
            s_ce[k] = 1'b0;
        end
        apply();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            s_wa[k] = '0; s_wd[k] = '0; s_ca[k] = '0;
            for (int i = 0; i < 4; i++) s_ra[k][i] = '0;
        end
        idle();
        #1 rst = 1'b1;
        chk_on = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sweep every address right after reset.
        for (int n = 0; n < 32; n++) begin
            s_ra[0][0] = 5'(n); s_ra[0][1] = 5'(31 - n); apply(); #1;
            chk("p1_rd", 256'(if0.rd), 256'd0);
            chk("p1_busy", 256'({if0.rd_busy, if0.busy_vec}), 256'd0);
            step();
        end

        // Write reg n = n, then read back.
        for (int n = 1; n < 32; n++) begin
            s_we[0] = 1'b1; s_wa[0] = 5'(n); s_wd[0] = 64'(n); apply(); step();
        end
        idle(); s_ra[0][0] = 5'd2; s_ra[0][1] = 5'd3; apply(); #1;
        chk("p2_readback", 256'(if0.rd), 256'h0000_0003_0000_0002);
        step();
        s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 64'hdead_beef; apply(); step();
        idle(); s_ra[0][0] = 5'd0; apply(); #1;
        chk("p2_zero_reg", 256'(if0.rd[31:0]), 256'd0);
        step();

        // Same-cycle bypass, then the registered value.
        s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 64'h55; s_ra[0][0] = 5'd5; apply(); #1;
        chk("p3_bypass", 256'(if0.rd[31:0]), 256'h55);
        step();
        idle(); #1;
        chk("p3_after", 256'(if0.rd[31:0]), 256'h55);
        step();

        // Claim, re-claim refused, writeback clears the busy bit.
        s_ce[0] = 1'b1; s_ca[0] = 5'd7; s_ra[0][1] = 5'd7; apply(); #1;
        chk("p4_claim_ok", 256'(if0.claim_ok), 256'd1);
        step();
        #1;
        chk("p4_busy7", 256'(if0.busy_vec[7]), 256'd1);
        chk("p4_rd_busy1", 256'(if0.rd_busy[1]), 256'd1);
        chk("p4_reclaim", 256'(if0.claim_ok), 256'd0);
        step();
        s_ce[0] = 1'b0; s_we[0] = 1'b1; s_wa[0] = 5'd7; s_wd[0] = 64'd9; apply(); #1;
        chk("p4_wb_busy", 256'(if0.rd_busy[1]), 256'd0);
        chk("p4_wb_rd1", 256'(if0.rd[63:32]), 256'd9);
        step();
        idle(); #1;
        chk("p4_busy7_clr", 256'(if0.busy_vec[7]), 256'd0);

        // Writeback and new claim to the same register in one cycle.
        s_ce[0] = 1'b1; s_ca[0] = 5'd4; apply(); step();
        s_we[0] = 1'b1; s_wa[0] = 5'd4; s_wd[0] = 64'h44; apply(); #1;
        chk("p5_claim_ok", 256'(if0.claim_ok), 256'd1);
        step();
        idle(); s_ra[0][0] = 5'd4; apply(); #1;
        chk("p5_busy4", 256'(if0.busy_vec[4]), 256'd1);
        chk("p5_rd4", 256'(if0.rd[31:0]), 256'h44);
        step();

        // Asynchronous reset between edges.
        s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 64'h33; apply(); step();
        idle(); s_ce[0] = 1'b1; s_ca[0] = 5'd3; apply(); step();
        idle(); s_ra[0][0] = 5'd3; apply(); #1;
        chk("p6_pre_rd3", 256'(if0.rd[31:0]), 256'h33);
        chk("p6_pre_busy3", 256'(if0.busy_vec[3]), 256'd1);
        s_ce[0] = 1'b1; s_ca[0] = 5'd9; apply();
        rst = 1'b1; #1;
        chk("p6_rst_rd", 256'(if0.rd), 256'd0);
        chk("p6_rst_busy", 256'(if0.busy_vec), 256'd0);
        chk("p6_rst_cok", 256'(if0.claim_ok), 256'd0);
        @(negedge clk); #1;
        rst = 1'b0; idle();
        step();
        chk("p6_post_rd3", 256'(if0.rd[31:0]), 256'd0);

        // Wide instance, with register 0 as an ordinary register.
        s_we[1] = 1'b1; s_wa[1] = 5'd0; s_wd[1] = 64'h1234_5678_9abc_def0; apply(); step();
        idle();
        for (int i = 0; i < 4; i++) s_ra[1][i] = 5'd0;
        s_ce[1] = 1'b1; s_ca[1] = 5'd0; apply(); #1;
        chk("w_rd0", 256'(if1.rd), {4{64'h1234_5678_9abc_def0}});
        chk("w_claim0", 256'(if1.claim_ok), 256'd1);
        step();
        idle(); #1;
        chk("w_busy0", 256'(if1.busy_vec[0]), 256'd1);
        chk("w_rd_busy", 256'(if1.rd_busy), 256'hf);
        step();

        // Random traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                s_we[k] = ($urandom_range(0, 1) == 1);
                s_wa[k] = 5'($urandom_range(0, nregs_of(k) - 1));
                s_wd[k] = {$urandom, $urandom};
                for (int i = 0; i < 4; i++) begin
                    s_ra[k][i] = ($urandom_range(0, 2) == 0) ? s_wa[k] :
                                 5'($urandom_range(0, nregs_of(k) - 1));
                end
                s_ce[k] = ($urandom_range(0, 4) < 2);
                s_ca[k] = ($urandom_range(0, 3) == 0) ? s_wa[k] :
                          5'($urandom_range(0, nregs_of(k) - 1));
            end
            apply();
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                @(negedge clk); #1;
                rst = 1'b0;
            end
            step();
        end

        idle();
        step();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
